// File: rtl/papilio_template_pkg.sv
// Shared constants for the Papilio Wishbone peripheral template:
// register map, bit positions and an address decode helper.
package papilio_template_pkg;

  localparam logic [15:0] ADDR_CONTROL = 16'h0000;
  localparam logic [15:0] ADDR_STATUS  = 16'h0004;
  localparam logic [15:0] ADDR_DATA    = 16'h0008;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_SOFT_RST = 1;
  localparam int STAT_READY    = 0;

  typedef enum logic [1:0] {
    REG_CONTROL,
    REG_STATUS,
    REG_DATA,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [15:0] adr);
    case (adr)
      ADDR_CONTROL: decode_addr = REG_CONTROL;
      ADDR_STATUS:  decode_addr = REG_STATUS;
      ADDR_DATA:    decode_addr = REG_DATA;
      default:      decode_addr = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/papilio_template_wb_if.sv
// Wishbone classic slave bus bundle for the Papilio template peripheral.
interface papilio_template_wb_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [15:0]           wb_adr_i;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_we_i;
  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/papilio_template_wb.sv
// Wishbone slave skeleton with CONTROL / STATUS / DATA registers; user logic
// hooks onto ctrl_enable, data_reg and user_status.
module papilio_template_wb
  import papilio_template_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  papilio_template_wb_if.slave wb
);

  logic                  ctrl_enable;
  logic                  soft_rst;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  taken;
  logic                  req;
  logic [DATA_WIDTH-1:0] rd_data;
  reg_sel_e              sel;

  // User hook: spare STATUS bits [DATA_WIDTH-1:1]; tie to hardware status here.
  logic [DATA_WIDTH-2:0] user_status;
  assign user_status = '0;

  // A held cyc/stb is accepted once; 'taken' blocks re-acceptance until the
  // master drops the request, so ack is one pulse per transaction.
  assign req = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o & ~taken;
  assign sel = decode_addr(wb.wb_adr_i);

  always_comb begin
    rd_data = '0;
    case (sel)
      REG_CONTROL: rd_data[CTRL_ENABLE] = ctrl_enable;
      REG_STATUS:  rd_data = {user_status, ctrl_enable & ~soft_rst};
      REG_DATA:    rd_data = data_reg;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_enable  <= 1'b0;
      soft_rst     <= 1'b0;
      data_reg     <= '0;
      taken        <= 1'b0;
      wb.wb_ack_o  <= 1'b0;
      wb.wb_dat_o  <= '0;
    end else begin
      wb.wb_ack_o <= req;
      soft_rst    <= 1'b0;

      if (!(wb.wb_cyc_i && wb.wb_stb_i)) taken <= 1'b0;
      else if (req)                      taken <= 1'b1;

      if (req) begin
        if (wb.wb_we_i) begin
          case (sel)
            REG_CONTROL: begin
              ctrl_enable <= wb.wb_dat_i[CTRL_ENABLE];
              soft_rst    <= wb.wb_dat_i[CTRL_SOFT_RST];
            end
            REG_DATA: data_reg <= wb.wb_dat_i;
            default: ;
          endcase
        end else begin
          wb.wb_dat_o <= rd_data;
        end
      end

      // Soft reset wins over the ENABLE value written by the same access.
      if (soft_rst) begin
        ctrl_enable <= 1'b0;
        data_reg    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_papilio_template_wb.sv
// Self-checking bench for papilio_template_wb: bus tasks push expected read
// data to a scoreboard queue, popped and compared when the DUT acks.
module tb_papilio_template_wb;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [DW-1:0] exp_q[$];

  papilio_template_wb_if #(.DATA_WIDTH(DW)) bus ();

  papilio_template_wb #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  // One transaction; hold keeps cyc/stb asserted that many cycles past the ack.
  task automatic wb_cycle(input logic [15:0] adr, input logic we,
                          input logic [DW-1:0] wdat, input int hold);
    int n;
    int acks;
    logic [DW-1:0] exp;
    exp = '0;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = wdat;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    n = 0;
    acks = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.wb_ack_o && n < 16);
    if (!bus.wb_ack_o) begin
      check("ack_timeout", 32'd0, 32'd1);
      if (!we && exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      acks = 1;
      if (!we) begin
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check($sformatf("rd_%04h", adr), bus.wb_dat_o, exp);
        end else begin
          check("sb_empty", 32'd1, 32'd0);
        end
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o) acks++;
    end
    bus_idle();
    @(posedge clk); #1;
    if (bus.wb_ack_o) acks++;
    if (n < 16) check("ack_pulses", acks, 1);
    if (!we && n < 16) check("rd_hold", bus.wb_dat_o, exp);
  endtask

  task automatic wb_write(input logic [15:0] adr, input logic [DW-1:0] d);
    wb_cycle(adr, 1'b1, d, 0);
  endtask

  task automatic wb_read(input logic [15:0] adr, input logic [DW-1:0] exp);
    exp_q.push_back(exp);
    wb_cycle(adr, 1'b0, '0, 0);
  endtask

  initial begin
    int n;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", bus.wb_ack_o, 0);
    check("rst_dat", bus.wb_dat_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    wb_read(16'h0000, 8'h00);
    wb_read(16'h0004, 8'h00);
    wb_read(16'h0008, 8'h00);

    wb_write(16'h0000, 8'h01);
    wb_read(16'h0000, 8'h01);
    wb_read(16'h0004, 8'h01);

    // Held request after ack must produce a single ack pulse.
    wb_cycle(16'h0008, 1'b1, 8'h42, 2);
    wb_read(16'h0008, 8'h42);
    wb_write(16'h0008, 8'hA5);
    wb_read(16'h0008, 8'hA5);

    // Soft reset clears ENABLE and DATA.
    wb_write(16'h0000, 8'h02);
    wb_read(16'h0000, 8'h00);
    wb_read(16'h0004, 8'h00);
    wb_read(16'h0008, 8'h00);

    // Soft reset overrides ENABLE written in the same access.
    wb_write(16'h0008, 8'h7E);
    wb_write(16'h0000, 8'h03);
    wb_read(16'h0000, 8'h00);
    wb_read(16'h0004, 8'h00);
    wb_read(16'h0008, 8'h00);

    wb_write(16'h0004, 8'hFF);
    wb_read(16'h0004, 8'h00);

    wb_write(16'h0008, 8'h11);
    wb_write(16'h0008, 8'h22);
    wb_write(16'h0008, 8'h33);
    wb_read(16'h0008, 8'h33);
    wb_write(16'h000C, 8'h99);
    wb_read(16'h000C, 8'h00);
    wb_read(16'h0009, 8'h00);
    wb_read(16'h0008, 8'h33);

    // Reset asserted during a write ack.
    wb_write(16'h0000, 8'h01);
    wb_read(16'h0008, 8'h33);
    bus.wb_adr_i = 16'h0008;
    bus.wb_dat_i = 8'h55;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.wb_ack_o && n < 16);
    check("mid_ack_seen", bus.wb_ack_o, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_ack", bus.wb_ack_o, 0);
    check("mid_rst_dat", bus.wb_dat_o, 0);
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    wb_read(16'h0000, 8'h00);
    wb_read(16'h0004, 8'h00);
    wb_read(16'h0008, 8'h00);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
